// File: rtl/gups_mem_responder_if.sv
// gups_mem_responder_if
//   Bus between the GUPS update initiator and the memory responder.
//
//   Handshake: the initiator raises req and holds it for a whole update
//   (one read phase, write=0, then one write phase, write=1). The responder
//   answers each phase with a single-cycle ready pulse; rdata is valid only
//   in the ready cycle of a read. After the write ack the initiator must drop
//   req for at least one cycle before the next update is accepted. Dropping
//   req while the responder waits for the write abandons the update. While
//   busy=1 (RAM initialisation) requests are not served.
//
//   Signals:
//     req, write, address[63:0], wdata[63:0]   initiator -> responder
//     rdata[63:0], ready, busy                  responder -> initiator
//     update_count[31:0], addr_err              responder status
interface gups_mem_responder_if;
    logic        req;
    logic        write;
    logic [63:0] address;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ready;
    logic        busy;
    logic [31:0] update_count;
    logic        addr_err;

    modport master (
        output req, write, address, wdata,
        input  rdata, ready, busy, update_count, addr_err
    );

    modport slave (
        input  req, write, address, wdata,
        output rdata, ready, busy, update_count, addr_err
    );
endinterface

// File: rtl/gups_mem_responder.sv
// gups_mem_responder
//   Memory-side responder for GUPS read-modify-write updates. Holds a local
//   word-addressed RAM of 2^ADDR_BITS 64-bit words, initialised to
//   mem[i] = i after every reset, serves one read then one write per update
//   and counts completed write phases.
//
//   Ports:
//     clk        clock
//     reset      synchronous, active-low reset
//     bus        gups_mem_responder_if slave modport (req/write/address/wdata
//                in; rdata/ready/busy/update_count/addr_err out)
//     state_dbg  current FSM state encoding, for observation only
//
//   Parameters:
//     ADDR_BITS  word-address width (RAM depth 2^ADDR_BITS)
//     LATENCY    cycles from read acceptance to the read ready pulse, 1..15
module gups_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    gups_mem_responder_if.slave    bus,
    output logic [2:0]             state_dbg
);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_ACK  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_WR_ACK  = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [63:0]            mem [DEPTH];
    logic [ADDR_BITS-1:0]   init_idx;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [ADDR_BITS-1:0]   in_addr;
    logic                   in_range_err;
    logic [3:0]             lat_cnt;
    logic [63:0]            rdata_q;
    logic [31:0]            count_q;
    logic                   err_q;

    logic                   accept_rd;
    logic                   accept_wr;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [63:0]            mem_wdata;

    assign in_addr      = bus.address[ADDR_BITS-1:0];
    assign in_range_err = |bus.address[63:ADDR_BITS];

    // Next state plus the RAM write port. The RAM has a single write port
    // shared by initialisation and write phases; only one can be active.
    always_comb begin
        state_next = state;
        accept_rd  = 1'b0;
        accept_wr  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = init_idx;
        mem_wdata  = {{(64-ADDR_BITS){1'b0}}, init_idx};
        case (state)
            S_INIT: begin
                mem_we = 1'b1;
                if (&init_idx) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req) begin
                    if (bus.write) begin
                        // Write without a preceding read.
                        accept_wr  = 1'b1;
                        mem_we     = 1'b1;
                        mem_waddr  = in_addr;
                        mem_wdata  = bus.wdata;
                        state_next = S_WR_ACK;
                    end else begin
                        accept_rd  = 1'b1;
                        state_next = (LATENCY == 1) ? S_RD_ACK : S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (lat_cnt == 4'd1) state_next = S_RD_ACK;
            end
            S_RD_ACK: begin
                state_next = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!bus.req) begin
                    state_next = S_IDLE;
                end else if (bus.write) begin
                    // Address was latched at the read; not re-sampled here.
                    accept_wr  = 1'b1;
                    mem_we     = 1'b1;
                    mem_waddr  = lat_addr;
                    mem_wdata  = bus.wdata;
                    state_next = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.req) state_next = S_IDLE;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_INIT;
        else        state <= state_next;
    end

    // A write sampled together with reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            init_idx <= '0;
            lat_addr <= '0;
            lat_cnt  <= 4'd0;
            rdata_q  <= 64'd0;
            count_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_INIT) init_idx <= init_idx + 1'b1;
            if (state == S_IDLE && bus.req) begin
                lat_addr <= in_addr;
                if (in_range_err) err_q <= 1'b1;
            end
            if (accept_rd) begin
                lat_cnt <= 4'(LATENCY - 1);
                if (LATENCY == 1) rdata_q <= mem[in_addr];
            end
            // The read is taken on the edge that raises ready, so a write to
            // the same word in this update always lands after it.
            if (state == S_RD_WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) rdata_q <= mem[lat_addr];
            end
            if (accept_wr) count_q <= count_q + 32'd1;
        end
    end

    assign bus.ready        = (state == S_RD_ACK) || (state == S_WR_ACK);
    assign bus.busy         = (state == S_INIT);
    assign bus.rdata        = rdata_q;
    assign bus.update_count = count_q;
    assign bus.addr_err     = err_q;
    assign state_dbg        = state;
endmodule
